// File: rtl/key_debounce_pkg.sv
// ----------------------------------------------------------------------------
// key_debounce_pkg
// Shared FSM package. It holds the debouncer state encodings, which the
// downstream control FSM also decodes, and the default confirmation length.
// ----------------------------------------------------------------------------
package key_debounce_pkg;

  // The encodings are fixed because the downstream control FSM and any
  // observer of the 'state' port decode them directly.
  typedef enum logic [1:0] {
    LOW      = 2'b00,
    CHK_HIGH = 2'b01,
    HIGH     = 2'b10,
    CHK_LOW  = 2'b11
  } state_t;

  // Number of consecutive confirming samples needed after entering a check
  // state. Legal range is 1..255 because the counter is 8 bits wide.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage : key_debounce_pkg

// File: rtl/key_debounce_if.sv
// ----------------------------------------------------------------------------
// key_debounce_if
// Bundles the debouncer's data signals: the raw key level going in, and the
// clean level, edge/glitch pulses and state coming out.
//   master : the debouncer side (drives A, A_rise, A_fall, glitch, state)
//   slave  : the consumer side (drives key_in, observes the outputs)
// ----------------------------------------------------------------------------
interface key_debounce_if;
  import key_debounce_pkg::*;

  logic       key_in;
  logic       A;
  logic       A_rise;
  logic       A_fall;
  logic       glitch;
  logic [1:0] state;

  modport master (
    input  key_in,
    output A, A_rise, A_fall, glitch, state
  );

  modport slave (
    output key_in,
    input  A, A_rise, A_fall, glitch, state
  );

endinterface : key_debounce_if

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer that brings an asynchronous level into the Clock
// domain. Both flops clear to 0 on synchronous active-low Reset.
//   Clock : system clock, rising edge
//   Reset : synchronous, active low
//   d     : asynchronous input level
//   q     : synchronized level (second flop)
// ----------------------------------------------------------------------------
module sync_2ff (
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic sync1;

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge value of its neighbour; with blocking assignments
  // d would pass straight through both stages in one edge.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule : sync_2ff

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// Debounces a raw key/sensor level. The level is synchronized, then a
// four-state FSM requires DEBOUNCE_CYCLES consecutive confirming samples
// after entering a check state before the clean output A follows.
//   Clock  : system clock, rising edge
//   Reset  : synchronous, active low
//   key_in : raw asynchronous, bouncing level
//   A      : debounced level
//   A_rise : one-cycle pulse in the first cycle A reads 1
//   A_fall : one-cycle pulse in the first cycle A reads 0
//   glitch : one-cycle pulse when a check state aborts
//   state  : registered FSM state (key_debounce_pkg::state_t encoding)
// Latency from the first edge sampling a stable new level to A changing is
// DEBOUNCE_CYCLES+3 edges: two synchronizer edges, one edge to enter the
// check state, then DEBOUNCE_CYCLES confirming edges.
// ----------------------------------------------------------------------------
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       key_in,
  output logic       A,
  output logic       A_rise,
  output logic       A_fall,
  output logic       glitch,
  output logic [1:0] state
);

  // Terminal count: a check completes on the sample that finds cnt here, so
  // cnt never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync2;
  state_t     cur_state, nxt_state;
  logic [7:0] cnt, nxt_cnt;
  logic       nxt_a, nxt_rise, nxt_fall, nxt_glitch;

  sync_2ff u_sync (
    .Clock (Clock),
    .Reset (Reset),
    .d     (key_in),
    .q     (sync2)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cur_state <= LOW;
      cnt       <= '0;
      A         <= 1'b0;
      A_rise    <= 1'b0;
      A_fall    <= 1'b0;
      glitch    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= nxt_cnt;
      A         <= nxt_a;
      A_rise    <= nxt_rise;
      A_fall    <= nxt_fall;
      glitch    <= nxt_glitch;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred. The pulse
  // defaults of 0 are also what makes each pulse last a single cycle.
  always_comb begin
    nxt_state  = cur_state;
    nxt_cnt    = cnt;
    nxt_a      = A;
    nxt_rise   = 1'b0;
    nxt_fall   = 1'b0;
    nxt_glitch = 1'b0;

    case (cur_state)
      LOW: begin
        if (sync2) begin
          nxt_state = CHK_HIGH;
          nxt_cnt   = '0;
        end
      end

      CHK_HIGH: begin
        if (!sync2) begin
          nxt_state  = LOW;
          nxt_cnt    = '0;
          nxt_glitch = 1'b1;
        end else if (cnt == CNT_LAST) begin
          nxt_state = HIGH;
          nxt_a     = 1'b1;
          nxt_rise  = 1'b1;
        end else begin
          nxt_cnt = cnt + 8'd1;
        end
      end

      HIGH: begin
        if (!sync2) begin
          nxt_state = CHK_LOW;
          nxt_cnt   = '0;
        end
      end

      CHK_LOW: begin
        if (sync2) begin
          nxt_state  = HIGH;
          nxt_cnt    = '0;
          nxt_glitch = 1'b1;
        end else if (cnt == CNT_LAST) begin
          nxt_state = LOW;
          nxt_a     = 1'b0;
          nxt_fall  = 1'b1;
        end else begin
          nxt_cnt = cnt + 8'd1;
        end
      end

      // Only reachable through an upset of the state register.
      default: begin
        nxt_state = LOW;
        nxt_cnt   = '0;
        nxt_a     = 1'b0;
      end
    endcase
  end

  assign state = cur_state;

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// ----------------------------------------------------------------------------
// tb_key_debounce
// Drives two debouncers (DEBOUNCE_CYCLES = 4 and = 1) from one key stimulus.
// Each edge, a behavioural model pushes the expected outputs into a queue;
// after the edge they are popped and compared with the DUT outputs.
// The model tracks how many consecutive synchronized samples disagree with
// the clean level: the level flips when that run reaches DEBOUNCE_CYCLES+1,
// and a run broken early is a glitch.
// ----------------------------------------------------------------------------
module tb_key_debounce;
  import key_debounce_pkg::*;

  localparam int DC0 = 4;
  localparam int DC1 = 1;

  typedef struct {
    logic [1:0] st;
    logic       a;
    logic       rise;
    logic       fall;
    logic       gl;
    logic [7:0] cnt;
  } exp_t;

  logic Clock;
  logic Reset;

  key_debounce_if bus0 ();
  key_debounce_if bus1 ();

  key_debounce #(.DEBOUNCE_CYCLES(DC0)) dut0 (
    .Clock  (Clock),
    .Reset  (Reset),
    .key_in (bus0.key_in),
    .A      (bus0.A),
    .A_rise (bus0.A_rise),
    .A_fall (bus0.A_fall),
    .glitch (bus0.glitch),
    .state  (bus0.state)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DC1)) dut1 (
    .Clock  (Clock),
    .Reset  (Reset),
    .key_in (bus1.key_in),
    .A      (bus1.A),
    .A_rise (bus1.A_rise),
    .A_fall (bus1.A_fall),
    .glitch (bus1.glitch),
    .state  (bus1.state)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  // Model state, one slot per DUT.
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_a  [2];
  int   m_run[2];

  // Per-window event counters for dut0.
  int   acc_rise, acc_fall, acc_gl, acc_achg, acc_high_states;
  logic prev_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int dcyc(input int i);
    return (i == 0) ? DC0 : DC1;
  endfunction

  // Predicts the outputs after the coming edge from the inputs set up now.
  task automatic model_step(input int i, input logic rst_v, input logic key_v);
    exp_t e;
    e.rise = 1'b0;
    e.fall = 1'b0;
    e.gl   = 1'b0;
    if (!rst_v) begin
      m_s1[i]  = 1'b0;
      m_s2[i]  = 1'b0;
      m_a[i]   = 1'b0;
      m_run[i] = 0;
    end else begin
      if (m_s2[i] != m_a[i]) begin
        m_run[i]++;
        if (m_run[i] == dcyc(i) + 1) begin
          m_a[i]   = m_s2[i];
          e.rise   = m_a[i];
          e.fall   = !m_a[i];
          m_run[i] = 0;
        end
      end else if (m_run[i] > 0) begin
        e.gl     = 1'b1;
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = key_v;
    end
    e.a   = m_a[i];
    e.st  = (m_run[i] == 0) ? (m_a[i] ? 2'b10 : 2'b00) : (m_a[i] ? 2'b11 : 2'b01);
    e.cnt = (m_run[i] == 0) ? 8'd0 : 8'(m_run[i] - 1);
    sb_q.push_back(e);
  endtask

  task automatic compare(input int i);
    exp_t       e;
    logic [1:0] st;
    logic       a, r, f, g;
    logic [7:0] c;
    if (sb_q.size() == 0) begin
      check($sformatf("d%0d_sb_empty", i), 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    if (i == 0) begin
      st = bus0.state; a = bus0.A; r = bus0.A_rise; f = bus0.A_fall; g = bus0.glitch; c = dut0.cnt;
    end else begin
      st = bus1.state; a = bus1.A; r = bus1.A_rise; f = bus1.A_fall; g = bus1.glitch; c = dut1.cnt;
    end
    check($sformatf("d%0d_state", i),  32'(st), 32'(e.st));
    check($sformatf("d%0d_A", i),      32'(a),  32'(e.a));
    check($sformatf("d%0d_A_rise", i), 32'(r),  32'(e.rise));
    check($sformatf("d%0d_A_fall", i), 32'(f),  32'(e.fall));
    check($sformatf("d%0d_glitch", i), 32'(g),  32'(e.gl));
    // The counter is only meaningful while a check is in progress.
    if (e.st[0]) check($sformatf("d%0d_cnt", i), 32'(c), 32'(e.cnt));
  endtask

  // Sets up inputs, predicts, clocks once, then compares 1 time unit later.
  task automatic drive_edge(input logic rst_v, input logic key_v);
    Reset       = rst_v;
    bus0.key_in = key_v;
    bus1.key_in = key_v;
    for (int i = 0; i < 2; i++) model_step(i, rst_v, key_v);
    @(posedge Clock);
    #1;
    for (int i = 0; i < 2; i++) compare(i);
    acc_rise        += int'(bus0.A_rise);
    acc_fall        += int'(bus0.A_fall);
    acc_gl          += int'(bus0.glitch);
    acc_achg        += int'(bus0.A != prev_a);
    acc_high_states += int'(bus0.state[1]);
    prev_a = bus0.A;
  endtask

  task automatic clr_acc();
    acc_rise = 0; acc_fall = 0; acc_gl = 0; acc_achg = 0; acc_high_states = 0;
  endtask

  // Hold key at 'lvl' for n edges and check both DUTs switch A exactly at
  // edge DEBOUNCE_CYCLES+3 of the window.
  task automatic hold_and_time(input logic lvl, input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      drive_edge(1'b1, lvl);
      if (k == DC0 + 2) check({tag, "_d0_before"}, 32'(bus0.A), 32'(!lvl));
      if (k == DC0 + 3) check({tag, "_d0_at"},     32'(bus0.A), 32'(lvl));
      if (k == DC1 + 2) check({tag, "_d1_before"}, 32'(bus1.A), 32'(!lvl));
      if (k == DC1 + 3) check({tag, "_d1_at"},     32'(bus1.A), 32'(lvl));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_a[i] = 1'b0; m_run[i] = 0;
    end
    prev_a      = 1'b0;
    Reset       = 1'b0;
    bus0.key_in = 1'b0;
    bus1.key_in = 1'b0;
    clr_acc();

    // Reset held for 3 edges with key high: everything stays cleared.
    for (int k = 0; k < 3; k++) begin
      drive_edge(1'b0, 1'b1);
      check("rst_state", 32'(bus0.state), 32'(LOW));
    end

    // Release with key high: normal upward debounce from post-release edge 1.
    clr_acc();
    hold_and_time(1'b1, 10, "rel_rise");
    check("rel_rise_count", 32'(acc_rise), 32'd1);

    // From HIGH, key falls and is held.
    clr_acc();
    hold_and_time(1'b0, 12, "fall");
    check("fall_count", 32'(acc_fall), 32'd1);
    check("fall_no_glitch", 32'(acc_gl), 32'd0);

    // Clean 0->1 held 12 cycles.
    clr_acc();
    hold_and_time(1'b1, 12, "rise");
    check("rise_count", 32'(acc_rise), 32'd1);
    check("rise_no_glitch", 32'(acc_gl), 32'd0);
    hold_and_time(1'b0, 12, "back_low");

    // Short 3-edge pulse: dut0 aborts its check with a single glitch.
    clr_acc();
    for (int k = 0; k < 3; k++) drive_edge(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) drive_edge(1'b1, 1'b0);
    check("short_glitch_count", 32'(acc_gl), 32'd1);
    check("short_no_rise", 32'(acc_rise), 32'd0);
    check("short_A_low", 32'(bus0.A), 32'd0);

    // Reset in the middle of a check (CHK_HIGH, cnt=2).
    for (int k = 0; k < 5; k++) drive_edge(1'b1, 1'b1);
    check("midchk_state", 32'(bus0.state), 32'(CHK_HIGH));
    check("midchk_cnt", 32'(dut0.cnt), 32'd2);
    drive_edge(1'b0, 1'b1);
    check("midrst_state", 32'(bus0.state), 32'(LOW));
    check("midrst_cnt", 32'(dut0.cnt), 32'd0);
    check("midrst_no_rise", 32'(bus0.A_rise), 32'd0);
    check("midrst_no_glitch", 32'(bus0.glitch), 32'd0);
    for (int k = 0; k < 8; k++) drive_edge(1'b1, 1'b0);

    // Key toggling every cycle: A never moves, only LOW/CHK_HIGH visited.
    clr_acc();
    for (int k = 0; k < 20; k++) drive_edge(1'b1, (k % 2 == 0) ? 1'b1 : 1'b0);
    check("tog_A_changes", 32'(acc_achg), 32'd0);
    check("tog_rise", 32'(acc_rise), 32'd0);
    check("tog_fall", 32'(acc_fall), 32'd0);
    check("tog_high_states", 32'(acc_high_states), 32'd0);
    check("tog_d1_A", 32'(bus1.A), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_key_debounce
